aes_encipher_seq: RTL and testbench

AES_ENCIPHER_SEQ -- requirements
Module: aes_encipher_seq

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_mixcolumns.sv | 18 +
 rtl/aes_encipher_seq.sv | 78 +++++++
 tb/tb_aes_encipher_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM encoding and GF(2^8) helpers
package aes_pkg;
  localparam logic KEYLEN_128 = 1'b0;
  localparam logic KEYLEN_256 = 1'b1;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_256 = 4'd14;
  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} fsm_t;
  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return gf_mul2(b) ^ b;
  endfunction
endpackage

// File: rtl/aes_mixcolumns.sv
// aes_mixcolumns: combinational MixColumns over a 128-bit column-major state
//   data  : state in, word c = column c, top byte = row 0
//   mixed : MixColumns(data)
module aes_mixcolumns
  import aes_pkg::*;
(
  input  logic [127:0] data,
  output logic [127:0] mixed
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] b0, b1, b2, b3;
    assign {b0, b1, b2, b3} = data[127-32*c -: 32];
    assign mixed[127-32*c -: 32] = {gf_mul2(b0) ^ gf_mul3(b1) ^ b2 ^ b3,
                                    b0 ^ gf_mul2(b1) ^ gf_mul3(b2) ^ b3,
                                    b0 ^ b1 ^ gf_mul2(b2) ^ gf_mul3(b3),
                                    gf_mul3(b0) ^ b1 ^ b2 ^ gf_mul2(b3)};
  end
endmodule

// File: rtl/aes_encipher_seq.sv
// aes_encipher_seq: iterative AES-128/256 encryption, one S-box word per cycle
//   next/keylen/block : start request, key length, plaintext (sampled when idle)
//   round/round_key   : round-key index out, key for that index in
//   sboxw/new_sboxw   : word to the shared external S-box and its substitution
//   new_block/ready   : ciphertext, held valid while ready is high
module aes_encipher_seq
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  output logic [127:0] new_block,
  output logic         ready
);
  fsm_t         fsm;
  logic [127:0] state, sr, mc;
  logic [3:0]   round_ctr, nr;
  logic [1:0]   word_ctr;
  logic         keylen_lat;
  // ShiftRows: row r of column c takes the byte from column (c+r) mod 4
  for (genvar c = 0; c < 4; c++) begin : g_sr_c
    for (genvar r = 0; r < 4; r++) begin : g_sr_r
      assign sr[127-8*(4*c+r) -: 8] = state[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
  aes_mixcolumns u_mix (.data(sr), .mixed(mc));
  assign nr = (keylen_lat == KEYLEN_256) ? NR_256 : NR_128;
  assign round = round_ctr;
  // word 0 sits in bits 127:96, so the word base is (3 - word_ctr) * 32
  assign sboxw = (fsm == SBOX) ? state[{~word_ctr, 5'd0} +: 32] : 32'h0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm        <= IDLE;
      ready      <= 1'b1;
      new_block  <= '0;
      state      <= '0;
      round_ctr  <= '0;
      word_ctr   <= '0;
      keylen_lat <= KEYLEN_128;
    end else begin
      case (fsm)
        IDLE: if (next) begin
          state      <= block;
          keylen_lat <= keylen;
          ready      <= 1'b0;
          round_ctr  <= '0;
          fsm        <= INIT;
        end
        INIT: begin
          state     <= state ^ round_key;
          round_ctr <= 4'd1;
          word_ctr  <= '0;
          fsm       <= SBOX;
        end
        SBOX: begin
          state[{~word_ctr, 5'd0} +: 32] <= new_sboxw;
          word_ctr <= word_ctr + 2'd1;
          fsm      <= (word_ctr == 2'd3) ? MAIN : SBOX;
        end
        MAIN: if (round_ctr == nr) begin
          new_block <= sr ^ round_key;
          ready     <= 1'b1;
          fsm       <= IDLE;
        end else begin
          state     <= mc ^ round_key;
          round_ctr <= round_ctr + 4'd1;
          fsm       <= SBOX;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_encipher_seq.sv
// tb_aes_encipher_seq: FIPS-197 vectors against a cycle-level reference model
module tb_aes_encipher_seq;
  logic         clk, reset_n, next, keylen;
  logic [127:0] block, round_key, new_block;
  logic [3:0]   round;
  logic [31:0]  sboxw, new_sboxw;
  logic         ready;
  int checks = 0, errors = 0;

  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] rk [0:15];

  aes_encipher_seq dut (
    .clk(clk), .reset_n(reset_n), .next(next), .keylen(keylen), .block(block),
    .round(round), .round_key(round_key), .sboxw(sboxw), .new_sboxw(new_sboxw),
    .new_block(new_block), .ready(ready)
  );

  assign round_key = rk[round];
  assign new_sboxw = {sbox_t[sboxw[31:24]], sbox_t[sboxw[23:16]], sbox_t[sboxw[15:8]], sbox_t[sboxw[7:0]]};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input bit last);
    logic [127:0] t = shift_rows(sub_bytes(s));
    return (last ? t : mix_columns(t)) ^ k;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [127:0] s = pt ^ rk[0];
    for (int i = 1; i <= nr; i++) s = aes_round(s, rk[i], i == nr);
    return s;
  endfunction

  task automatic load_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nk = kl ? 8 : 4;
    int nr = kl ? 14 : 10;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) t = sub_word(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Reference model: tracks idle/busy, cycles since the accepting edge, and the
  // per-round state entering each S-box pass.
  bit           m_busy = 0, m_ready = 1;
  int           m_k = 0, m_nr = 10;
  logic [3:0]   m_round = 0;
  logic [127:0] m_block = '0, m_res = '0, m_s;
  logic [127:0] trace [0:13];

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_busy = 0; m_ready = 1; m_block = '0; m_round = 0; m_k = 0;
    end else if (m_busy) begin
      m_k++;
      if (m_k == 1 + 5*m_nr) begin
        m_busy = 0; m_ready = 1; m_block = m_res; m_round = 4'(m_nr);
      end
    end else if (next) begin
      m_busy = 1; m_ready = 0; m_k = 0;
      m_nr = keylen ? 14 : 10;
      m_s = block ^ rk[0];
      for (int i = 1; i <= m_nr; i++) begin
        trace[i-1] = m_s;
        m_s = aes_round(m_s, rk[i], i == m_nr);
      end
      m_res = m_s;
    end
  end

  logic [3:0]  er;
  logic [31:0] esw;
  initial forever begin
    @(negedge clk);
    er = m_round;
    esw = 32'h0;
    if (m_busy) begin
      er = 4'd0;
      if (m_k >= 1) begin
        er = 4'(1 + (m_k-1)/5);
        if ((m_k-1) % 5 < 4) esw = trace[(m_k-1)/5][127-32*((m_k-1)%5) -: 32];
      end
    end
    check("mon ready", 128'(ready), 128'(m_ready));
    check("mon new_block", new_block, m_block);
    check("mon round", 128'(round), 128'(er));
    check("mon sboxw", 128'(sboxw), 128'(esw));
  end

  // Called at a falling edge; starts an operation and measures latency to ready.
  task automatic run_op(input logic [127:0] pt, input logic kl, input logic [127:0] exp,
                        input int lat, input bit disturb, input string name);
    int n = 0;
    check({name, " model"}, encrypt(pt, kl ? 14 : 10), exp);
    block = pt; keylen = kl; next = 1;
    @(negedge clk);
    next = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
      if (disturb) begin
        next = (n == 10);
        keylen = (n >= 10 && n < 30) ? ~kl : kl;
        if (n == 10) block = ~pt;
      end
    end
    if (n >= 200) $display("FAIL %s timeout: got no ready after %0d cycles, expected %0d", name, n, lat);
    check({name, " latency"}, 128'(n), 128'(lat));
    check({name, " result"}, new_block, exp);
  endtask

  initial begin
    int n, m;
    logic [7:0] p;
    clk = 0; reset_n = 1; next = 0; keylen = 0; block = '0;
    for (int x = 0; x < 256; x++) begin
      p = 8'h01;
      if (x == 0) p = 8'h00;
      else repeat (254) p = gmul(p, 8'(x));
      sbox_t[x] = p ^ rotl(p, 1) ^ rotl(p, 2) ^ rotl(p, 3) ^ rotl(p, 4) ^ 8'h63;
    end
    #2 reset_n = 0;
    repeat (3) @(negedge clk);
    check("reset ready", 128'(ready), 128'(1));
    check("reset new_block", new_block, '0);
    check("reset round", 128'(round), '0);
    check("sbox 00", 128'(sbox_t[8'h00]), 128'h63);
    check("sbox 53", 128'(sbox_t[8'h53]), 128'hed);
    load_key({B_KEY, 128'h0}, 1'b0);
    check("key b rk10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    reset_n = 1;
    run_op(B_PT, 1'b0, B_CT, 51, 1'b0, "fips_b");
    load_key(C3_KEY, 1'b1);
    run_op(C_PT, 1'b1, C3_CT, 71, 1'b0, "c3_256");
    load_key({C1_KEY, 128'h0}, 1'b0);
    run_op(C_PT, 1'b0, C1_CT, 51, 1'b1, "c1_disturb");
    block = B_PT; keylen = 0; next = 1;
    @(negedge clk);
    next = 0;
    repeat (19) @(negedge clk);
    check("mid-op busy", 128'(ready), '0);
    #2 reset_n = 0;
    #1;
    check("async reset ready", 128'(ready), 128'(1));
    check("async reset new_block", new_block, '0);
    check("async reset round", 128'(round), '0);
    @(negedge clk);
    reset_n = 1;
    run_op(C_PT, 1'b0, C1_CT, 51, 1'b0, "c1_after_reset");
    load_key({B_KEY, 128'h0}, 1'b0);
    block = B_PT; keylen = 0; next = 1;
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b first latency", 128'(n), 128'(51));
    check("b2b first result", new_block, B_CT);
    m = 0;
    do begin
      @(negedge clk);
      m++;
      if (m == 1) begin
        check("b2b restarted", 128'(ready), '0);
        next = 0;
      end
    end while (!ready && m < 200);
    check("b2b second gap", 128'(m), 128'(52));
    check("b2b second result", new_block, B_CT);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
